// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: load-use,
// EX-resolved redirects and multi-cycle data-memory waits with a hang trap.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_reg_dest,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 id_ex_stall,
    output logic                 ex_mem_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
    output logic                 mem_busy,
    output logic                 mem_error,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

    logic mw, lu, br;

    assign mw = mem_req & ~mem_ready;
    assign br = ex_branch_taken;
    assign lu = ex_mem_read && (ex_reg_dest != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_reg_dest)) ||
                 (id_uses_rs2 && (id_rs2 == ex_reg_dest)));

    // State, wait counter and stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Next-state: wait_cnt already reads 1 on entry to MEM_WAIT
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (mw) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mw) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        stall_count_d = stall_count_q;
        if (pc_stall && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    // Pipeline control: reset > ERROR > memory wait > redirect > load-use
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst_n) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if ((state_q == ERROR) || mw) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (br) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign mem_busy    = (state_q == MEM_WAIT);
    assign mem_error   = (state_q == ERROR);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, 4-bit stall counter).
module tb_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_reg_dest;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic          mem_req, mem_ready;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic          mem_busy, mem_error;
    logic [CW-1:0] stall_count;
    logic [7:0]    ctl;

    int n_chk  = 0;
    int n_fail = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_reg_dest(ex_reg_dest), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .mem_busy(mem_busy), .mem_error(mem_error),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // {pc,if_id,id_ex,ex_mem stalls, if_id,id_ex,ex_mem,mem_wb flushes}
    assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_reg_dest = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_lu_rs2();
        ex_mem_read = 1'b1; ex_reg_dest = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        mem_req = 1'b1;
        ex_branch_taken = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (ctl !== 8'h0F) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 8'h0F); end
        n_chk++; if (stall_count !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
        n_chk++; if (mem_error !== 1'b0 || mem_busy !== 1'b0) begin n_fail++; $display("FAIL reset_status: got err=%b busy=%b want 0 0", mem_error, mem_busy); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        n_chk++; if (ctl !== 8'h00) begin n_fail++; $display("FAIL post_reset_ctl: got %b want %b", ctl, 8'h00); end
        @(negedge clk); #1;
        n_chk++; if (stall_count !== 4'd0 || mem_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_status: got cnt=%0d busy=%b want 0 0", stall_count, mem_busy); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu_rs2();
        #1;
        n_chk++; if (ctl !== 8'hC4) begin n_fail++; $display("FAIL lu_rs2_ctl: got %b want %b", ctl, 8'hC4); end
        @(negedge clk);
        ex_reg_dest = 5'd0; id_rs2 = 5'd0;
        #1;
        n_chk++; if (ctl !== 8'h00) begin n_fail++; $display("FAIL lu_x0_ctl: got %b want %b", ctl, 8'h00); end
        n_chk++; if (stall_count !== 4'd1) begin n_fail++; $display("FAIL lu_cnt1: got %0d want 1", stall_count); end
        @(negedge clk);
        ex_reg_dest = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
        #1;
        n_chk++; if (ctl !== 8'hC4) begin n_fail++; $display("FAIL lu_rs1_ctl: got %b want %b", ctl, 8'hC4); end
        @(negedge clk);
        id_uses_rs1 = 1'b0;
        #1;
        n_chk++; if (ctl !== 8'h00) begin n_fail++; $display("FAIL lu_unused_ctl: got %b want %b", ctl, 8'h00); end
        n_chk++; if (stall_count !== 4'd2) begin n_fail++; $display("FAIL lu_cnt2: got %0d want 2", stall_count); end
    endtask

    task automatic test_branch();
        do_reset();
        set_lu_rs2();
        ex_branch_taken = 1'b1;
        #1;
        n_chk++; if (ctl !== 8'h0C) begin n_fail++; $display("FAIL br_lu_ctl: got %b want %b", ctl, 8'h0C); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (stall_count !== 4'd0 || ctl !== 8'h00) begin n_fail++; $display("FAIL br_after: got cnt=%0d ctl=%b want 0 00000000", stall_count, ctl); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        n_chk++; if (ctl !== 8'hF1 || mem_busy !== 1'b0) begin n_fail++; $display("FAIL mw1: got ctl=%b busy=%b want 11110001 0", ctl, mem_busy); end
        @(negedge clk);
        ex_branch_taken = 1'b1;
        set_lu_rs2();
        #1;
        n_chk++; if (ctl !== 8'hF1 || mem_busy !== 1'b1) begin n_fail++; $display("FAIL mw2_br_ignored: got ctl=%b busy=%b want 11110001 1", ctl, mem_busy); end
        @(negedge clk);
        ex_branch_taken = 1'b0;
        #1;
        n_chk++; if (ctl !== 8'hF1 || mem_busy !== 1'b1) begin n_fail++; $display("FAIL mw3: got ctl=%b busy=%b want 11110001 1", ctl, mem_busy); end
        @(negedge clk);
        idle();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        n_chk++; if (ctl !== 8'h00 || mem_busy !== 1'b1) begin n_fail++; $display("FAIL mw_ready: got ctl=%b busy=%b want 00000000 1", ctl, mem_busy); end
        n_chk++; if (stall_count !== 4'd3) begin n_fail++; $display("FAIL mw_cnt: got %0d want 3", stall_count); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (mem_busy !== 1'b0 || stall_count !== 4'd3) begin n_fail++; $display("FAIL mw_release: got busy=%b cnt=%0d want 0 3", mem_busy, stall_count); end
        // request withdrawn mid-wait also releases
        mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        n_chk++; if (ctl !== 8'h00 || mem_busy !== 1'b1) begin n_fail++; $display("FAIL mw_drop: got ctl=%b busy=%b want 00000000 1", ctl, mem_busy); end
        @(negedge clk); #1;
        n_chk++; if (mem_busy !== 1'b0 || stall_count !== 4'd4) begin n_fail++; $display("FAIL mw_drop_after: got busy=%b cnt=%0d want 0 4", mem_busy, stall_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_chk++; if (ctl !== 8'hF1 || mem_error !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got ctl=%b err=%b want 11110001 0", k, ctl, mem_error); end
            @(negedge clk);
        end
        idle();
        #1;
        n_chk++; if (mem_error !== 1'b1 || mem_busy !== 1'b0) begin n_fail++; $display("FAIL to_error: got err=%b busy=%b want 1 0", mem_error, mem_busy); end
        n_chk++; if (ctl !== 8'hF1) begin n_fail++; $display("FAIL to_error_ctl: got %b want %b", ctl, 8'hF1); end
        n_chk++; if (stall_count !== 4'd4) begin n_fail++; $display("FAIL to_cnt: got %0d want 4", stall_count); end
        repeat (20) @(negedge clk);
        #1;
        n_chk++; if (mem_error !== 1'b1 || ctl !== 8'hF1) begin n_fail++; $display("FAIL to_sticky: got err=%b ctl=%b want 1 11110001", mem_error, ctl); end
        n_chk++; if (stall_count !== 4'hF) begin n_fail++; $display("FAIL cnt_saturate: got %0d want 15", stall_count); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (mem_error !== 1'b0 || stall_count !== 4'd0 || ctl !== 8'h0F) begin n_fail++; $display("FAIL to_async_rst: got err=%b cnt=%0d ctl=%b want 0 0 00001111", mem_error, stall_count, ctl); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++; if (ctl !== 8'h00 || mem_error !== 1'b0) begin n_fail++; $display("FAIL to_recover: got ctl=%b err=%b want 00000000 0", ctl, mem_error); end
    endtask

    task automatic test_timeout_ready();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_chk++; if (ctl !== 8'h00) begin n_fail++; $display("FAIL tr_ready_ctl: got %b want %b", ctl, 8'h00); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (mem_error !== 1'b0 || mem_busy !== 1'b0 || ctl !== 8'h00) begin n_fail++; $display("FAIL tr_no_error: got err=%b busy=%b ctl=%b want 0 0 00000000", mem_error, mem_busy, ctl); end
        n_chk++; if (stall_count !== 4'd3) begin n_fail++; $display("FAIL tr_cnt: got %0d want 3", stall_count); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_timeout_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard and sequencing controller for the 5-stage RV32 core.
- Drives the stall and synchronous-flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three conditions:
  - load-use data hazards;
  - taken branches/jumps resolved in EX;
  - multi-cycle data-memory accesses signalled by a request/ready handshake.
- Counts stall cycles and traps hung memory accesses with a timeout FSM.

## Interface
- MEM_TIMEOUT, 16: consecutive not-ready memory cycles before entering ERROR (≥2).
- CNT_WIDTH, 32: width of stall cycle counter.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_reg_dest  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch/jump in EX redirects the PC this cycle.
- mem_req  in  1  instruction in MEM is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the register.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble on the next edge.
- mem_busy  out  1  FSM in MEM_WAIT.
- mem_error  out  1  FSM in ERROR (sticky).
- stall_count  out  CNT_WIDTH  saturating count of cycles with pc_stall=1.

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Stall and flush outputs are combinational from the state and inputs. The state, wait counter and stall_count are registered.
- While rst_n=0:
  - all four *_flush = 1 and all *_stall = 0, so the pipeline registers clear;
  - mem_busy = 0, mem_error = 0, stall_count = 0.
- Conditions:
  - mw (memory wait) = mem_req & !mem_ready.
  - lu (load-use) = ex_mem_read & ex_reg_dest≠0 & ((id_uses_rs1 & id_rs1==ex_reg_dest) | (id_uses_rs2 & id_rs2==ex_reg_dest)).
  - br = ex_branch_taken.
- Priority: ERROR > mw > br > lu.
- ERROR:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall = 1;
  - mem_wb_flush = 1; all other flushes = 0.
  - Exit only via rst_n.
- mw (RUN or MEM_WAIT):
  - pc, IF/ID, ID/EX and EX/MEM stalls = 1; mem_wb_flush = 1 (bubble into WB).
  - br and lu are ignored: EX is frozen and re-evaluated after release.
- br without mw:
  - if_id_flush = 1 and id_ex_flush = 1; no stalls.
  - A simultaneous lu is discarded because the ID instruction is squashed.
- lu alone: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1 (one bubble).
- Otherwise all outputs are 0.
- FSM transitions:
  - RUN→MEM_WAIT on mw.
  - MEM_WAIT→RUN on mem_ready, or on mem_req dropping.
  - MEM_WAIT→ERROR when wait_cnt == MEM_TIMEOUT-1 and mw still holds.
- wait_cnt:
  - cleared in RUN;
  - increments each MEM_WAIT cycle with mw;
  - counts the first waiting cycle (RUN with mw) as 1 on entry.
- stall_count increments every cycle with pc_stall=1 and saturates at all-ones.

## Timing
- Hazard response has zero latency: stall/flush are valid in the same cycle as the causing inputs and act on the next clock edge.
- Memory access of N wait cycles:
  - stalls are asserted for exactly N cycles;
  - in the cycle with mem_ready=1 stalls are 0, and MEM/WB captures the result on that edge.
- A load-use hazard costs exactly 1 cycle; lu naturally clears next cycle because the bubble occupies EX.
- mem_busy rises on the edge after the first mw cycle and falls on the edge after mem_ready.
- ERROR is entered on the edge ending the MEM_TIMEOUT-th consecutive mw cycle.
- mem_ready asserted in that same cycle prevents ERROR.
- Reset asserted mid-wait or in ERROR returns to RUN asynchronously, with the counters cleared.

## Test plan
- Reset: rst_n=0 → all flush=1, all stall=0, stall_count=0, mem_error=0. Release → all outputs 0 with idle inputs.
- Load-use: ex_mem_read=1, ex_reg_dest=5, id_rs2=5, id_uses_rs2=1 → one cycle of pc_stall=if_id_stall=id_ex_flush=1; stall_count=1.
  - Repeat with ex_reg_dest=0 → no stall.
- Branch with lu in the same cycle: ex_branch_taken=1 → if_id_flush=id_ex_flush=1, pc_stall=0.
- Memory wait, mem_req=1 with mem_ready low for 3 cycles then high:
  - stalls and mem_wb_flush high for exactly 3 cycles;
  - mem_busy high for 3 cycles; stall_count=3;
  - a branch_taken asserted during the wait is ignored.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → ERROR after the 4th wait cycle; mem_error=1 and full stall persist; rst_n pulse clears them.
  - With mem_ready=1 on the 4th cycle → no ERROR.
